// File: rtl/sobel_ctrl_master.sv
// Avalon-MM master that writes a command to the Sobel control PIO and polls its status
// register until done or a poll limit. Optional clear write: SOBEL_CTRL_MASTER_AUTOCLEAR_EN.
module sobel_ctrl_master #(
  parameter int          ADDR_W       = 2,
  parameter int          CTRL_ADDR    = 0,
  parameter int          STATUS_ADDR  = 1,
  parameter logic [31:0] DONE_MASK    = 32'h0000_0001,
  parameter int          MAX_POLLS    = 1024,
  parameter int          POLL_GAP     = 4,
  parameter int          READ_LATENCY = 1,
  localparam int         PC_W         = $clog2(MAX_POLLS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        cmd,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [7:0]        status,
  output logic [PC_W-1:0]   poll_count,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata
);

  // Bus handshake: a transfer is presented by chipselect plus exactly one strobe and
  // completes on the first cycle avm_waitrequest is low; everything holds until then.

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CMD, S_RD_REQ, S_RD_WAIT, S_CHECK, S_GAP, S_WR_CLR, S_DONE
  } state_t;

`ifdef SOBEL_CTRL_MASTER_AUTOCLEAR_EN
  localparam state_t S_FINISH = S_WR_CLR;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  localparam int GAP_W = $clog2(POLL_GAP + 1) + 1;

  state_t           state, state_nxt;
  logic [2:0]       lat_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             hit_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_WR_CMD;
      S_WR_CMD:  if (!avm_waitrequest) state_nxt = S_RD_REQ;
      S_RD_REQ:  if (!avm_waitrequest) state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (lat_cnt == 3'(READ_LATENCY - 1)) state_nxt = S_CHECK;
      S_CHECK: begin
        // A done status on the final poll wins over the timeout.
        if (hit_q || (poll_count == PC_W'(MAX_POLLS))) state_nxt = S_FINISH;
        else if (POLL_GAP == 0)                        state_nxt = S_RD_REQ;
        else                                           state_nxt = S_GAP;
      end
      S_GAP:     if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_nxt = S_RD_REQ;
      S_WR_CLR:  if (!avm_waitrequest) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      status         <= 8'h00;
      poll_count     <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read       <= 1'b0;
      avm_writedata  <= 32'h0;
      lat_cnt        <= 3'd0;
      gap_cnt        <= '0;
      hit_q          <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);

      // Bus outputs are registered from the next state so they line up with the state.
      avm_chipselect <= (state_nxt == S_WR_CMD) || (state_nxt == S_RD_REQ) ||
                        (state_nxt == S_WR_CLR);
      avm_write_n    <= !((state_nxt == S_WR_CMD) || (state_nxt == S_WR_CLR));
      avm_read       <= (state_nxt == S_RD_REQ);
      if ((state_nxt == S_WR_CMD) || (state_nxt == S_WR_CLR))
        avm_address <= ADDR_W'(CTRL_ADDR);
      else if (state_nxt == S_RD_REQ)
        avm_address <= ADDR_W'(STATUS_ADDR);

      if (state == S_IDLE && start) begin
        avm_writedata <= {24'h0, cmd};
        poll_count    <= '0;
        timeout       <= 1'b0;
      end
      if (state_nxt == S_WR_CLR) avm_writedata <= 32'h0;

      if (state == S_RD_WAIT) lat_cnt <= lat_cnt + 3'd1;
      else                    lat_cnt <= 3'd0;

      if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                gap_cnt <= '0;

      if (state == S_RD_WAIT && state_nxt == S_CHECK) begin
        status     <= avm_readdata[7:0];
        hit_q      <= |(avm_readdata & DONE_MASK);
        poll_count <= poll_count + 1'b1;
      end

      if (state == S_CHECK && !hit_q && (poll_count == PC_W'(MAX_POLLS)))
        timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sobel_ctrl_master.sv
// Bench for sobel_ctrl_master: Avalon slave model, write scoreboard and scenario tasks.
module tb_sobel_ctrl_master;
  localparam int MAXP = 8;
  localparam int GAP  = 4;
  localparam int LAT  = 1;
  localparam int PC_W = $clog2(MAXP + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      cmd = 8'h00;
  logic            busy, done, timeout;
  logic [7:0]      status;
  logic [PC_W-1:0] poll_count;
  logic [1:0]      avm_address;
  logic            avm_chipselect, avm_write_n, avm_read;
  logic [31:0]     avm_writedata;
  logic            avm_waitrequest = 1'b0;
  logic [31:0]     avm_readdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int stall_left = 0;
  logic [33:0] exp_q[$];
  logic [31:0] status_q[$];
  int          rd_cyc_q[$];

  sobel_ctrl_master #(.MAX_POLLS(MAXP), .POLL_GAP(GAP), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .busy(busy), .done(done),
    .timeout(timeout), .status(status), .poll_count(poll_count),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_read(avm_read), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata)
  );

  always #5 clk = ~clk;

  // One cycle: slave response, bus rule checks and scoreboard for completed writes.
  task automatic step();
    logic [33:0] exp;
    @(negedge clk);
    cyc++;
    if (avm_chipselect && !avm_write_n && stall_left > 0) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avm_waitrequest = 1'b0;
    end
    if (avm_chipselect || avm_read || !avm_write_n) begin
      n_checks++;
      if (!avm_chipselect || (avm_read == !avm_write_n)) begin
        n_fail++;
        $display("FAIL bus_strobes cs=%b read=%b write_n=%b, required cs=1 with one strobe",
                 avm_chipselect, avm_read, avm_write_n);
      end
    end
    if (avm_chipselect && !avm_write_n && !avm_waitrequest) begin
      wr_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%0d data=%h, none expected", avm_address, avm_writedata);
      end else begin
        exp = exp_q.pop_front();
        if ({avm_address, avm_writedata} !== exp) begin
          n_fail++;
          $display("FAIL write_data got addr=%0d data=%h, required addr=%0d data=%h",
                   avm_address, avm_writedata, exp[33:32], exp[31:0]);
        end
      end
    end
    if (avm_chipselect && avm_read && !avm_waitrequest) begin
      rd_cnt++;
      rd_cyc_q.push_back(cyc);
      n_checks++;
      if (avm_address !== 2'd1) begin
        n_fail++;
        $display("FAIL read_addr got %0d, required 1", avm_address);
      end
      avm_readdata = (status_q.size() > 0) ? status_q.pop_front() : 32'h0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic do_start(input logic [7:0] c);
    start = 1'b1;
    cmd   = c;
    step();
    start = 1'b0;
    cmd   = 8'h00;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      step();
      if (done) ok = 1'b1;
    end
  endtask

  task automatic push_op(input logic [7:0] c);
    exp_q.push_back({2'd0, 24'h0, c});
`ifdef SOBEL_CTRL_MASTER_AUTOCLEAR_EN
    exp_q.push_back({2'd0, 32'h0});
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if ({busy, done, timeout, status, poll_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_status busy=%b done=%b timeout=%b status=%h poll=%0d, required all 0",
               busy, done, timeout, status, poll_count);
    end
    n_checks++;
    if ({avm_chipselect, avm_write_n, avm_read, avm_address, avm_writedata} !== {3'b010, 34'h0}) begin
      n_fail++;
      $display("FAIL reset_bus cs=%b wn=%b rd=%b addr=%0d wd=%h, required cs=0 wn=1 rd=0 addr=0 wd=0",
               avm_chipselect, avm_write_n, avm_read, avm_address, avm_writedata);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_poll_done();
    bit ok;
    int d0;
    status_q.delete();
    rd_cyc_q.delete();
    status_q.push_back(32'h0);
    status_q.push_back(32'h0);
    status_q.push_back(32'h1);
    push_op(8'hA5);
    d0 = done_cnt;
    rd_cnt = 0;
    do_start(8'hA5);
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL poll_done_wait got no done, required done"); end
    n_checks++;
    if (rd_cnt !== 3 || status !== 8'h01 || poll_count !== 3 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL poll_done_result reads=%0d status=%h poll=%0d timeout=%b, required 3 01 3 0",
               rd_cnt, status, poll_count, timeout);
    end
    n_checks++;
    if (rd_cyc_q.size() == 3 &&
        (rd_cyc_q[1] - rd_cyc_q[0] != LAT + 2 + GAP || rd_cyc_q[2] - rd_cyc_q[1] != LAT + 2 + GAP)) begin
      n_fail++;
      $display("FAIL poll_gap intervals %0d %0d, required %0d",
               rd_cyc_q[1] - rd_cyc_q[0], rd_cyc_q[2] - rd_cyc_q[1], LAT + 2 + GAP);
    end
    n_checks++;
`ifdef SOBEL_CTRL_MASTER_AUTOCLEAR_EN
    if (rd_cyc_q.size() == 3 && done_cyc - rd_cyc_q[2] != LAT + 3) begin
`else
    if (rd_cyc_q.size() == 3 && done_cyc - rd_cyc_q[2] != LAT + 2) begin
`endif
      n_fail++;
      $display("FAIL done_latency got %0d cycles after last read accept", done_cyc - rd_cyc_q[2]);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL poll_done_end busy=%b pulses=%0d pending_writes=%0d, required 0 1 0",
               busy, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    status_q.delete();
    push_op(8'h5A);
    rd_cnt = 0;
    do_start(8'h5A);
    wait_done(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timeout_wait got no done, required done"); end
    n_checks++;
    if (rd_cnt !== MAXP || timeout !== 1'b1 || poll_count !== MAXP || status !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_result reads=%0d timeout=%b poll=%0d status=%h, required %0d 1 %0d 00",
               rd_cnt, timeout, poll_count, status, MAXP, MAXP);
    end
    step();
    n_checks++;
    if (exp_q.size() !== 0 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_end pending_writes=%0d timeout=%b, required 0 1", exp_q.size(), timeout);
    end
  endtask

  task automatic test_wait_stall();
    bit ok;
    status_q.delete();
    status_q.push_back(32'h1);
    push_op(8'h3C);
    rd_cnt = 0;
    stall_left = 5;
    do_start(8'h3C);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      n_checks++;
      if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_read !== 1'b0 ||
          avm_address !== 2'd0 || avm_writedata !== 32'h3C) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d cs=%b wn=%b rd=%b addr=%0d wd=%h, required 1 0 0 0 3c",
                 i, avm_chipselect, avm_write_n, avm_read, avm_address, avm_writedata);
      end
    end
    wait_done(200, ok);
    n_checks++;
    if (!ok || rd_cnt !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL stall_result done=%b reads=%0d pending_writes=%0d, required 1 1 0",
               ok, rd_cnt, exp_q.size());
    end
    step();
  endtask

  task automatic test_busy_ignore();
    bit ok;
    int w0, d0;
    status_q.delete();
    status_q.push_back(32'h0);
    status_q.push_back(32'h1);
    push_op(8'h77);
    d0 = done_cnt;
    w0 = wr_cnt;
    do_start(8'h77);
    for (int i = 0; i < 3; i++) step();
    do_start(8'hFF);
    wait_done(200, ok);
    for (int i = 0; i < 30; i++) step();
    n_checks++;
`ifdef SOBEL_CTRL_MASTER_AUTOCLEAR_EN
    if (!ok || wr_cnt - w0 !== 2 || done_cnt - d0 !== 1 || poll_count !== 2 || exp_q.size() !== 0) begin
`else
    if (!ok || wr_cnt - w0 !== 1 || done_cnt - d0 !== 1 || poll_count !== 2 || exp_q.size() !== 0) begin
`endif
      n_fail++;
      $display("FAIL busy_ignore done=%b writes=%0d pulses=%0d poll=%0d pending=%0d",
               ok, wr_cnt - w0, done_cnt - d0, poll_count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w0, r0;
    status_q.delete();
    exp_q.push_back({2'd0, 32'h22});
    r0 = rd_cnt;
    do_start(8'h22);
    for (int i = 0; i < 50 && rd_cnt == r0; i++) step();
    step();
    step();
    step();
    w0 = wr_cnt;
    reset = 1'b1;
    step();
    n_checks++;
    if (avm_chipselect !== 1'b0 || avm_read !== 1'b0 || avm_write_n !== 1'b1 || busy !== 1'b0 ||
        poll_count !== 0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid cs=%b rd=%b wn=%b busy=%b poll=%0d done=%b, required 0 0 1 0 0 0",
               avm_chipselect, avm_read, avm_write_n, busy, poll_count, done);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (wr_cnt !== w0 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_no_clear writes=%0d pending=%0d, required 0 0", wr_cnt - w0, exp_q.size());
    end
    status_q.push_back(32'h1);
    push_op(8'h11);
    do_start(8'h11);
    n_checks++;
    if (poll_count !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_begin poll=%0d busy=%b, required 0 1", poll_count, busy);
    end
    wait_done(200, ok);
    n_checks++;
    if (!ok || poll_count !== 1 || status !== 8'h01 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_result done=%b poll=%0d status=%h timeout=%b, required 1 1 01 0",
               ok, poll_count, status, timeout);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    status_q.delete();
    status_q.push_back(32'h1);
    status_q.push_back(32'h3);
    push_op(8'h44);
    push_op(8'h55);
    do_start(8'h44);
    wait_done(200, ok);
    step();
    n_checks++;
    if (!ok || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle done=%b busy=%b, required 1 0", ok, busy);
    end
    do_start(8'h55);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept busy=%b, required 1", busy);
    end
    wait_done(200, ok);
    step();
    n_checks++;
    if (!ok || status !== 8'h03 || poll_count !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_result done=%b status=%h poll=%0d pending=%0d, required 1 03 1 0",
               ok, status, poll_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_poll_done();
    test_timeout();
    test_wait_stall();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_ctrl_master.md
Name: sobel_ctrl_master

Overview:
- Avalon-MM master that drives the 8-bit Sobel control PIO slave from the fabric side, i.e. the initiator end of that PIO interface.
- On a start request it writes a command byte to the PIO control register, then polls a status register until a done bit is set or a poll limit expires.
- Optionally clears the control register, then reports the result to the local requester.
- Sits between a hardware sequencer (frame scheduler) and the Sobel control/status PIOs.

Parameters:
- ADDR_W, 2: avm_address width.
- CTRL_ADDR, 0: word address of the control register.
- STATUS_ADDR, 1: word address of the status register.
- DONE_MASK, 32'h0000_0001: status bits; any set bit means done.
- MAX_POLLS, 1024: maximum status reads before timeout (>=1).
- POLL_GAP, 4: idle cycles between consecutive status reads (>=0).
- READ_LATENCY, 1: cycles from read acceptance to valid avm_readdata (1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- cmd  in  8  command byte, latched with an accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  last operation hit MAX_POLLS; held until next accepted start.
- status  out  8  avm_readdata[7:0] of the last status read; held.
- poll_count  out  clog2(MAX_POLLS+1)  completed status reads in the current/last operation.
- avm_address  out  ADDR_W  word address.
- avm_chipselect  out  1  transfer select.
- avm_write_n  out  1  active-low write strobe.
- avm_read  out  1  read strobe.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall; a transfer completes on the first cycle it is low.
- avm_readdata  in  32  read data.

Behaviour:
- Reset (synchronous, high): state=IDLE; busy=0, done=0, timeout=0, status=0, poll_count=0, avm_chipselect=0, avm_write_n=1, avm_read=0, avm_address=0, avm_writedata=0.
- Reset mid-operation aborts the operation; strobes drop at that edge. No clear write is issued.
- States: IDLE, WR_CMD, RD_REQ, RD_WAIT, CHECK, GAP, WR_CLR, DONE.
- All bus outputs are registered.
- IDLE:
  - start=1: latch cmd, clear poll_count and timeout, go to WR_CMD.
  - start while busy is ignored (no queueing).
- WR_CMD:
  - Drive chipselect=1, write_n=0, address=CTRL_ADDR, writedata={24'b0,cmd}.
  - Hold all of these unchanged while waitrequest=1.
  - When waitrequest=0, go to RD_REQ.
- RD_REQ:
  - Drive chipselect=1, read=1, write_n=1, address=STATUS_ADDR.
  - Hold while waitrequest=1; on acceptance go to RD_WAIT.
- RD_WAIT:
  - Strobes low; wait READ_LATENCY cycles after acceptance.
  - Sample avm_readdata on that cycle: status<=readdata[7:0]; poll_count += 1.
  - Go to CHECK.
- CHECK (one cycle):
  - If (sampled & DONE_MASK) != 0, go to WR_CLR.
  - Else if poll_count == MAX_POLLS: timeout<=1, go to WR_CLR.
  - Else go to GAP (or straight to RD_REQ if POLL_GAP=0).
  - Done has priority over timeout when both hold on the final poll.
- GAP: count POLL_GAP idle cycles, then go to RD_REQ.
- WR_CLR:
  - Write 32'h0 to CTRL_ADDR with the same handshake as WR_CMD, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - busy falls on the cycle after DONE.
  - A start on that same cycle (busy=0) is accepted.
- poll_count never exceeds MAX_POLLS; status and timeout stay valid until the next accepted start.
- Write and read are never asserted together.
- chipselect is asserted only in WR_CMD, RD_REQ and WR_CLR.

Optional Feature:
- Macro: SOBEL_CTRL_MASTER_AUTOCLEAR_EN.
- Defined: WR_CLR is present as described above.
- Undefined: CHECK goes directly to DONE, and the control register keeps cmd after completion. Bus writes per operation are then exactly 1 instead of 2.

Test Plan:
- Slave returns status 32'h0 twice then 32'h1; start with cmd=8'hA5, waitrequest=0 -> write 0xA5 to address 0, 3 reads of address 1 with 4-cycle gaps, write 0x0 to address 0; done pulses once; status=8'h01, poll_count=3, timeout=0.
- MAX_POLLS=8, status always 0 -> exactly 8 reads, then clear write; done pulses with timeout=1, poll_count=8.
- Slave holds waitrequest=1 for 5 cycles on the command write -> address, writedata=0x3C and write_n stay stable for 6 cycles; no read issued before the write completes.
- Start pulsed again while busy, with cmd=8'hFF -> ignored; the only command write observed carries the original byte.
- Reset asserted during GAP -> next cycle all strobes inactive, busy=0, no clear write; a new start with cmd=8'h11 runs normally, poll_count restarts at 0.
- Build without SOBEL_CTRL_MASTER_AUTOCLEAR_EN, status 32'h1 on first read -> one write (cmd) and one read, no write of 0x0; done 2 cycles after read data is sampled.
